// File: rtl/acumulador_ula_p.sv
// Signed accumulator with an integrated ALU, status flags and a valid/ready command port.
// Shifts run serially, one bit per cycle, while the block holds in_ready low.
module acumulador_ula_p #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             done,
    output logic             err
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;
    localparam logic [WIDTH-1:0] W_AS_B  = WIDTH'(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH);

    logic [0:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic             dir_r;
    logic [WIDTH-1:0] acc_r;
    logic             flag_z_r, flag_n_r, flag_c_r, flag_v_r;
    logic             done_r, err_r;

    logic             cin_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic             add_v_s, sub_v_s;
    logic [CW-1:0]    n_s;
    logic [WIDTH-1:0] res_s;
    logic             c_s, v_s, legal_s, start_shift_s;
    logic [WIDTH-1:0] step_s;
    logic             out_bit_s;

    // ADC/SBB share the adder/subtractor with ADD/SUB; op[3] separates them.
    assign cin_s   = op[3] & flag_c_r;
    assign sum_s   = {1'b0, acc_r} + {1'b0, b} + {{WIDTH{1'b0}}, cin_s};
    assign diff_s  = {1'b0, acc_r} - {1'b0, b} - {{WIDTH{1'b0}}, cin_s};
    assign add_v_s = (acc_r[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != acc_r[WIDTH-1]);
    assign sub_v_s = (acc_r[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != acc_r[WIDTH-1]);
    assign n_s     = (b >= W_AS_B) ? CNT_MAX : CW'(b);

    assign step_s    = dir_r ? {acc_r[WIDTH-1], acc_r[WIDTH-1:1]} : {acc_r[WIDTH-2:0], 1'b0};
    assign out_bit_s = dir_r ? acc_r[0] : acc_r[WIDTH-1];

    assign in_ready = (state_r == S_IDLE);
    assign acc      = acc_r;
    assign flag_z   = flag_z_r;
    assign flag_n   = flag_n_r;
    assign flag_c   = flag_c_r;
    assign flag_v   = flag_v_r;
    assign done     = done_r;
    assign err      = err_r;

    // Single-cycle ALU result and flags for the command currently offered.
    always_comb begin
        res_s         = acc_r;
        c_s           = 1'b0;
        v_s           = 1'b0;
        legal_s       = 1'b1;
        start_shift_s = 1'b0;
        case (op)
            4'd0, 4'd10: begin
                res_s = sum_s[WIDTH-1:0];
                c_s   = sum_s[WIDTH];
                v_s   = add_v_s;
            end
            4'd1, 4'd11: begin
                res_s = diff_s[WIDTH-1:0];
                c_s   = diff_s[WIDTH];
                v_s   = sub_v_s;
            end
            4'd2:    res_s = acc_r & b;
            4'd3:    res_s = acc_r | b;
            4'd4:    res_s = acc_r ^ b;
            4'd5:    res_s = ~b;
            4'd6, 4'd7: begin
                if (n_s != {CW{1'b0}}) begin
                    start_shift_s = 1'b1;
                end else begin
                    start_shift_s = 1'b0;
                end
            end
            4'd8:    res_s = b;
            4'd9:    res_s = {WIDTH{1'b0}};
            default: legal_s = 1'b0;
        endcase
    end

    // Command acceptance, serial shifting and flag/done/err registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            cnt_r    <= {CW{1'b0}};
            dir_r    <= 1'b0;
            acc_r    <= {WIDTH{1'b0}};
            flag_z_r <= 1'b0;
            flag_n_r <= 1'b0;
            flag_c_r <= 1'b0;
            flag_v_r <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        if (!legal_s) begin
                            done_r <= 1'b1;
                            err_r  <= 1'b1;
                        end else if (start_shift_s) begin
                            state_r <= S_SHIFT;
                            cnt_r   <= n_s;
                            dir_r   <= (op == 4'd7);
                        end else begin
                            acc_r    <= res_s;
                            flag_z_r <= (res_s == {WIDTH{1'b0}});
                            flag_n_r <= res_s[WIDTH-1];
                            flag_c_r <= c_s;
                            flag_v_r <= v_s;
                            done_r   <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    acc_r <= step_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r  <= S_IDLE;
                        flag_z_r <= (step_s == {WIDTH{1'b0}});
                        flag_n_r <= step_s[WIDTH-1];
                        flag_c_r <= out_bit_s;
                        flag_v_r <= 1'b0;
                        done_r   <= 1'b1;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acumulador_ula_p.sv
// Bench for acumulador_ula_p (WIDTH = 8): directed test-plan steps plus random
// commands checked against an integer-arithmetic reference model.
module tb_acumulador_ula_p;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] acc;
    logic             flag_z, flag_n, flag_c, flag_v, done, err;

    int n_cmp;
    int n_fail;

    logic [7:0] m_acc;
    logic       m_z, m_n, m_c, m_v;

    acumulador_ula_p #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .b(b), .acc(acc), .flag_z(flag_z), .flag_n(flag_n),
        .flag_c(flag_c), .flag_v(flag_v), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int to_s(input int u);
        return (u >= 128) ? u - 256 : u;
    endfunction

    // Value of a after s single-bit shifts in the direction of opcode o.
    function automatic int shifted(input int o, input int a, input int s);
        if (o == 6) return (a << s) & 255;
        return (to_s(a) >>> s) & 255;
    endfunction

    // Reference model: applies one command; returns the shift length and whether err is expected.
    task automatic model(input int o, input int bv, output int lat, output logic eerr);
        int a_u, a_s, b_s, cin, r, sr, sh, res;
        a_u  = int'(m_acc);
        a_s  = to_s(a_u);
        b_s  = to_s(bv);
        cin  = (o >= 10) ? int'(m_c) : 0;
        sh   = (bv > 8) ? 8 : bv;
        lat  = 0;
        eerr = 1'b0;
        res  = 0;
        case (o)
            0, 10: begin
                r = a_u + bv + cin;  sr = a_s + b_s + cin;
                res = r & 255; m_c = (r > 255); m_v = (sr > 127 || sr < -128);
            end
            1, 11: begin
                r = a_u - bv - cin;  sr = a_s - b_s - cin;
                res = r & 255; m_c = (r < 0); m_v = (sr > 127 || sr < -128);
            end
            2: begin res = a_u & bv; m_c = 0; m_v = 0; end
            3: begin res = a_u | bv; m_c = 0; m_v = 0; end
            4: begin res = a_u ^ bv; m_c = 0; m_v = 0; end
            5: begin res = (~bv) & 255; m_c = 0; m_v = 0; end
            6: begin
                res = shifted(6, a_u, sh); m_v = 0; lat = sh;
                m_c = (sh == 0) ? 1'b0 : 1'((a_u >> (8 - sh)) & 1);
            end
            7: begin
                res = shifted(7, a_u, sh); m_v = 0; lat = sh;
                m_c = (sh == 0) ? 1'b0 : 1'((a_s >>> (sh - 1)) & 1);
            end
            8: begin res = bv; m_c = 0; m_v = 0; end
            9: begin res = 0;  m_c = 0; m_v = 0; end
            default: begin res = a_u; eerr = 1'b1; end
        endcase
        if (!eerr) begin
            m_acc = 8'(res);
            m_z   = (res == 0);
            m_n   = (res >= 128);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_acc"}, int'(acc), int'(m_acc));
        chk({tag, "_z"}, int'(flag_z), int'(m_z));
        chk({tag, "_n"}, int'(flag_n), int'(m_n));
        chk({tag, "_c"}, int'(flag_c), int'(m_c));
        chk({tag, "_v"}, int'(flag_v), int'(m_v));
    endtask

    // Issue one command, follow it to done (bounded), and check timing, acc and flags.
    task automatic do_cmd(input int o, input int bv, input string tag);
        int   lat, i, a0;
        logic eerr;
        a0 = int'(m_acc);
        @(negedge clk);
        chk({tag, "_ready_pre"}, int'(in_ready), 1);
        in_valid = 1'b1; op = 4'(o); b = 8'(bv);
        model(o, bv, lat, eerr);
        @(negedge clk);
        in_valid = 1'b0; op = 4'd0; b = 8'd0;
        i = 1;
        while (!done && i <= WIDTH + 2) begin
            chk({tag, "_ready_busy"}, int'(in_ready), 0);
            chk({tag, "_acc_step"}, int'(acc), shifted(o, a0, i - 1));
            @(negedge clk);
            i++;
        end
        chk({tag, "_latency"}, i, lat + 1);
        chk({tag, "_ready_done"}, int'(in_ready), 1);
        chk({tag, "_err"}, int'(err), int'(eerr));
        chk_state(tag);
        @(negedge clk);
        chk({tag, "_done_once"}, int'(done), 0);
        chk({tag, "_err_once"}, int'(err), 0);
    endtask

    initial begin
        int o, bv;
        n_cmp = 0; n_fail = 0;
        in_valid = 1'b0; op = 4'd0; b = 8'd0;
        m_acc = 8'd0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_state("reset");
        chk("reset_ready", int'(in_ready), 1);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        rst_n = 1'b1;

        do_cmd(8, 8'h7F, "load7f");
        do_cmd(0, 8'h01, "add_ovf");
        chk("add_ovf_lit", int'({acc, flag_n, flag_v, flag_c, flag_z}), int'({8'h80, 4'b1100}));
        do_cmd(8, 8'h00, "load0");
        do_cmd(1, 8'h01, "sub_borrow");
        do_cmd(8, 8'h01, "load1");
        do_cmd(0, 8'hFF, "add_wrap");
        do_cmd(10, 8'h00, "adc_carry");
        chk("adc_lit", int'({acc, flag_c}), int'({8'h01, 1'b0}));
        do_cmd(8, 8'h81, "load81");
        do_cmd(6, 3, "shl3");
        do_cmd(8, 8'h81, "load81b");
        do_cmd(6, 1, "shl1");
        do_cmd(8, 8'h90, "load90");
        do_cmd(7, 9, "sar9");
        chk("sar9_lit", int'({acc, flag_c, flag_n}), int'({8'hFF, 2'b11}));
        do_cmd(6, 0, "shl0");
        do_cmd(8, 8'h55, "load55");
        do_cmd(15, 8'h3C, "illegal");

        // Command held on in_valid during a shift is taken on the first ready cycle.
        do_cmd(8, 8'h01, "load01");
        @(negedge clk);
        in_valid = 1'b1; op = 4'd6; b = 8'd3;
        @(negedge clk);
        chk("hold_busy", int'(in_ready), 0);
        op = 4'd8; b = 8'h33;
        repeat (3) @(negedge clk);
        chk("hold_shift_done", int'({done, in_ready, acc}), int'({2'b11, 8'h08}));
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold_load_done", int'({done, acc, flag_c}), int'({1'b1, 8'h33, 1'b0}));
        m_acc = 8'h33; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
        @(negedge clk);
        chk("hold_done_once", int'(done), 0);

        // Reset in the middle of an 8-bit shift aborts it.
        do_cmd(8, 8'h81, "load81c");
        @(negedge clk);
        in_valid = 1'b1; op = 4'd6; b = 8'd8;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_acc = 8'd0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
        chk_state("midrst");
        chk("midrst_ready", int'(in_ready), 1);
        chk("midrst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_nodone", int'(done), 0);
        do_cmd(8, 8'h12, "load12");

        for (int k = 0; k < 60; k++) begin
            o  = int'($urandom_range(0, 15));
            bv = (o == 6 || o == 7) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 255));
            do_cmd(o, bv, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
